// File: rtl/reg_dst_queue.sv
// reg_dst_queue: writeback destination select plus a small queue of pending
// destinations for multicycle ops, with read-after-write hazard flags.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Reg_Dst, rt, rd   destination select (00 rt, 01 rd, 10 CONST_A, 11 CONST_B)
//   push, pop, flush  enqueue selected dst / retire head / discard all entries
//   rs_chk, rt_chk    source indices checked against pending entries
//   dst_out           combinational selected destination
//   head_dst          oldest pending destination (registered, 0 when empty)
//   count, full, empty  occupancy, derived from registered state only
//   hazard_rs/rt      source matches a valid pending entry (index 0 never)
//
// Optional build macro: REG_DST_ZERO_DROP_EN -- pushes of index 0 are
// acknowledged but not stored.
module reg_dst_queue #(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CONST_A = 31,
   parameter int unsigned CONST_B = 29
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 Reg_Dst,
   input  logic [REG_W-1:0]           rt,
   input  logic [REG_W-1:0]           rd,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [REG_W-1:0]           rs_chk,
   input  logic [REG_W-1:0]           rt_chk,
   output logic [REG_W-1:0]           dst_out,
   output logic [REG_W-1:0]           head_dst,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       hazard_rs,
   output logic                       hazard_rt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [REG_W-1:0] entry_q [DEPTH];
   logic [REG_W-1:0] entry_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [REG_W-1:0] head_q, head_d;

   logic pop_acc, push_ok, push_acc;
   logic hz_rs, hz_rt;

   always_comb begin
      unique case (Reg_Dst)
         2'b00:   dst_out = rt;
         2'b01:   dst_out = rd;
         2'b10:   dst_out = REG_W'(CONST_A);
         default: dst_out = REG_W'(CONST_B);
      endcase
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   assign pop_acc = pop && !empty;
   // A pop in the same cycle frees a slot, so a full queue can still take a push.
   assign push_ok = push && (!full || pop_acc);
`ifdef REG_DST_ZERO_DROP_EN
   assign push_acc = push_ok && (dst_out != '0);
`else
   assign push_acc = push_ok;
`endif

   always_comb begin
      entry_d  = entry_q;
      valid_d  = valid_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         valid_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Clear before set: on push+pop while full, wr_ptr == rd_ptr and the
         // freshly written entry must end up valid.
         if (pop_acc) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
         end
         if (push_acc) begin
            entry_d[wr_ptr_q] = dst_out;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end
         if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
         else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
      end
      head_d = (count_d != '0) ? entry_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   // Entry payload needs no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   always_comb begin
      hz_rs = 1'b0;
      hz_rt = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (entry_q[i] == rs_chk)) hz_rs = 1'b1;
         if (valid_q[i] && (entry_q[i] == rt_chk)) hz_rt = 1'b1;
      end
   end

   assign hazard_rs = hz_rs && (rs_chk != '0);
   assign hazard_rt = hz_rt && (rt_chk != '0);

   assign head_dst = head_q;
   assign count    = count_q;

endmodule

// File: tb/tb_reg_dst_queue.sv
module tb_reg_dst_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Reg_Dst;
   logic [4:0] rt, rd, rs_chk, rt_chk;
   logic       push, pop, flush;
   logic [4:0] dst_out, head_dst;
   logic [2:0] count;
   logic       full, empty, hazard_rs, hazard_rt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_dst_queue #(.REG_W(5), .DEPTH(4), .CONST_A(31), .CONST_B(29)) dut (
      .clk(clk), .reset(reset), .Reg_Dst(Reg_Dst), .rt(rt), .rd(rd),
      .push(push), .pop(pop), .flush(flush), .rs_chk(rs_chk), .rt_chk(rt_chk),
      .dst_out(dst_out), .head_dst(head_dst), .count(count), .full(full),
      .empty(empty), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt)
   );

`ifdef REG_DST_ZERO_DROP_EN
   localparam int ZC = 0;
`else
   localparam int ZC = 1;
`endif

   typedef struct {
      logic [1:0] rdst;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       push;
      logic       pop;
      logic       flush;
      logic [4:0] rs;
      logic [4:0] rtc;
      int         exp_cnt;
      int         exp_head;
   } vec_t;

   vec_t       vecs[$];
   logic [4:0] sq[$];   // scoreboard of pending destinations, oldest first

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [4:0] model_dst(input logic [1:0] c, input logic [4:0] t, input logic [4:0] d);
      case (c)
         2'b00:   return t;
         2'b01:   return d;
         2'b10:   return 5'd31;
         default: return 5'd29;
      endcase
   endfunction

   function automatic bit in_sq(input logic [4:0] x);
      if (x == 0) return 1'b0;
      foreach (sq[i]) if (sq[i] == x) return 1'b1;
      return 1'b0;
   endfunction

   function automatic vec_t mk(input logic [1:0] c, input logic [4:0] t, input logic [4:0] d,
                               input logic pu, input logic po, input logic fl,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input int ec, input int eh);
      vec_t v;
      v.rdst = c; v.rt = t; v.rd = d; v.push = pu; v.pop = po; v.flush = fl;
      v.rs = s1; v.rtc = s2; v.exp_cnt = ec; v.exp_head = eh;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      logic [4:0] d;
      logic [4:0] popped;
      bit         pop_ok, push_ok;
      string      tag;
      tag = $sformatf("v%0d", idx);
      Reg_Dst = v.rdst; rt = v.rt; rd = v.rd;
      push = v.push; pop = v.pop; flush = v.flush;
      rs_chk = v.rs; rt_chk = v.rtc;
      #1;
      d = model_dst(v.rdst, v.rt, v.rd);
      chk({tag, " dst_out"}, int'(dst_out), int'(d));
      chk({tag, " hazard_rs"}, int'(hazard_rs), int'(in_sq(v.rs)));
      chk({tag, " hazard_rt"}, int'(hazard_rt), int'(in_sq(v.rtc)));
      pop_ok  = v.pop && (sq.size() > 0);
      push_ok = v.push && ((sq.size() < 4) || pop_ok);
`ifdef REG_DST_ZERO_DROP_EN
      if (d == 0) push_ok = 1'b0;
`endif
      if (v.flush) begin
         sq.delete();
      end else begin
         if (pop_ok) begin
            popped = sq.pop_front();
            chk({tag, " retired head"}, int'(head_dst), int'(popped));
         end
         if (push_ok) sq.push_back(d);
      end
      @(posedge clk);
      #1;
      chk({tag, " count"}, int'(count), v.exp_cnt);
      chk({tag, " head_dst"}, int'(head_dst), v.exp_head);
      chk({tag, " full"}, int'(full), int'(v.exp_cnt == 4));
      chk({tag, " empty"}, int'(empty), int'(v.exp_cnt == 0));
      chk({tag, " scoreboard size"}, int'(count), sq.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] codes[4];
      logic [4:0] dexp[4];
      codes = '{2'b00, 2'b01, 2'b10, 2'b11};
      dexp  = '{5'd5, 5'd9, 5'd31, 5'd29};

      reset = 1'b1; Reg_Dst = 2'b00; rt = '0; rd = '0;
      push = 1'b0; pop = 1'b0; flush = 1'b0; rs_chk = '0; rt_chk = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // Combinational select and reset state
      rt = 5'd5; rd = 5'd9;
      for (int i = 0; i < 4; i++) begin
         Reg_Dst = codes[i];
         #1;
         chk($sformatf("sel%0d dst_out", i), int'(dst_out), int'(dexp[i]));
      end
      chk("reset empty", int'(empty), 1);
      chk("reset full", int'(full), 0);
      chk("reset count", int'(count), 0);
      chk("reset head", int'(head_dst), 0);
      rs_chk = 5'd5; rt_chk = 5'd9; #1;
      chk("reset hazard_rs", int'(hazard_rs), 0);
      chk("reset hazard_rt", int'(hazard_rt), 0);
      @(posedge clk); #1;

      //            rdst   rt     rd    pu po fl  rs     rtc    cnt head
      // single push, hazard, pop, pop-on-empty
      vecs.push_back(mk(2'b01, 5'd0, 5'd7, 1, 0, 0, 5'd0, 5'd0, 1, 7));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 0, 0, 5'd7, 5'd8, 1, 7));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 0, 0, 5'd8, 5'd7, 1, 7));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd7, 5'd0, 0, 0));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd7, 5'd0, 0, 0));
      // fill, drop on full, drain
      vecs.push_back(mk(2'b01, 5'd0, 5'd1, 1, 0, 0, 5'd0, 5'd0, 1, 1));
      vecs.push_back(mk(2'b01, 5'd0, 5'd2, 1, 0, 0, 5'd1, 5'd0, 2, 1));
      vecs.push_back(mk(2'b01, 5'd0, 5'd3, 1, 0, 0, 5'd2, 5'd1, 3, 1));
      vecs.push_back(mk(2'b01, 5'd0, 5'd4, 1, 0, 0, 5'd3, 5'd4, 4, 1));
      vecs.push_back(mk(2'b01, 5'd0, 5'd6, 1, 0, 0, 5'd4, 5'd3, 4, 1));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd6, 5'd1, 3, 2));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd2, 5'd0, 2, 3));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd0, 5'd3, 1, 4));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd4, 5'd4, 0, 0));
      // full with simultaneous push+pop, wrap-around
      vecs.push_back(mk(2'b01, 5'd0, 5'd11, 1, 0, 0, 5'd0, 5'd0, 1, 11));
      vecs.push_back(mk(2'b01, 5'd0, 5'd12, 1, 0, 0, 5'd0, 5'd0, 2, 11));
      vecs.push_back(mk(2'b01, 5'd0, 5'd13, 1, 0, 0, 5'd0, 5'd0, 3, 11));
      vecs.push_back(mk(2'b01, 5'd0, 5'd14, 1, 0, 0, 5'd0, 5'd0, 4, 11));
      vecs.push_back(mk(2'b01, 5'd0, 5'd10, 1, 1, 0, 5'd11, 5'd10, 4, 12));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd10, 5'd12, 3, 13));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd13, 5'd0, 2, 14));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd0, 5'd14, 1, 10));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 1, 0, 5'd10, 5'd0, 0, 0));
      // flush beats push
      vecs.push_back(mk(2'b10, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 1, 31));
      vecs.push_back(mk(2'b11, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 2, 31));
      vecs.push_back(mk(2'b00, 5'd21, 5'd0, 1, 0, 0, 5'd0, 5'd0, 3, 31));
      vecs.push_back(mk(2'b01, 5'd0, 5'd24, 1, 1, 1, 5'd21, 5'd29, 0, 0));
      vecs.push_back(mk(2'b01, 5'd0, 5'd0, 0, 0, 0, 5'd21, 5'd24, 0, 0));
      // index 0
      vecs.push_back(mk(2'b00, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, ZC, 0));
      vecs.push_back(mk(2'b00, 5'd0, 5'd0, 0, 0, 0, 5'd0, 5'd0, ZC, 0));
      vecs.push_back(mk(2'b00, 5'd0, 5'd0, 0, 1, 0, 5'd0, 5'd0, 0, 0));

      foreach (vecs[i]) apply(vecs[i], i);

      // Reset in the middle of activity clears queue state
      Reg_Dst = 2'b01; rd = 5'd17; push = 1'b1; pop = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset count", int'(count), 1);
      reset = 1'b1; rd = 5'd18;
      @(posedge clk); #1;
      reset = 1'b0; push = 1'b0; rs_chk = 5'd17; rt_chk = 5'd18; #1;
      chk("mid reset count", int'(count), 0);
      chk("mid reset head", int'(head_dst), 0);
      chk("mid reset hazard_rs", int'(hazard_rs), 0);
      chk("mid reset hazard_rt", int'(hazard_rt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_dst_queue.md
Name: reg_dst_queue

Overview:
Parametrised successor to the register-destination select mux.
- Selects the writeback destination index (rt, rd, or one of two constant registers) and exposes it combinationally.
- Also queues selected destinations for multicycle ops (mult/div/mem) whose writeback completes later.
- Flags read-after-write hazards against pending entries.
- Sits between the control unit and the register-file write port.

Parameters:
REG_W, 5, width of a register index.
DEPTH, 4, pending-destination entries; power of two, >= 2.
CONST_A, 31, index selected when Reg_Dst = 2'b10 (return address).
CONST_B, 29, index selected when Reg_Dst = 2'b11 (stack pointer).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
Reg_Dst  in  2  destination select: 00 rt, 01 rd, 10 CONST_A, 11 CONST_B.
rt  in  REG_W  rt field.
rd  in  REG_W  rd field.
push  in  1  enqueue the currently selected destination.
pop  in  1  retire the head entry (writeback done).
flush  in  1  discard all pending entries.
rs_chk  in  REG_W  source index to check for a hazard.
rt_chk  in  REG_W  second source index to check for a hazard.
dst_out  out  REG_W  combinational selected destination.
head_dst  out  REG_W  oldest pending destination (registered).
count  out  clog2(DEPTH)+1  number of valid entries.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
hazard_rs  out  1  rs_chk matches a valid entry.
hazard_rt  out  1  rt_chk matches a valid entry.

Behaviour:
- Clocking: single clock clk; reset is synchronous and active-high; all state updates on the rising edge of clk.
- dst_out: purely combinational from Reg_Dst/rt/rd; all four codes are defined, no X output.
- Storage: circular buffer of DEPTH entries with rd_ptr and wr_ptr (clog2(DEPTH) bits, natural wrap) and a count register.
- Reset (reset=1 at an edge): rd_ptr=0, wr_ptr=0, count=0, head_dst=0, all valid bits cleared. Resulting outputs: empty=1, full=0, hazard_rs=hazard_rt=0. Entry contents need not be cleared.
- Push accepted when push=1 and (!full or pop accepted in the same cycle).
  - Writes dst_out into the entry at wr_ptr and sets its valid bit.
  - Increments wr_ptr.
- Pop accepted when pop=1 and !empty.
  - Clears the valid bit at rd_ptr and increments rd_ptr.
  - Pop while empty is ignored; no state change.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Push while full with no pop: dropped silently; state unchanged.
- Push and pop while empty: push accepted, pop ignored; count becomes 1.
- Push and pop while full: both accepted; count stays DEPTH; the new entry lands in the freed slot.
- flush=1 has priority over push/pop: all valid bits cleared, rd_ptr=wr_ptr=0, count=0 next cycle.
- Priority order: reset > flush > push/pop.
- head_dst: registered copy of the entry at rd_ptr after the update; 0 when empty. Latency from an accepted push into an empty queue to head_dst valid is 1 cycle.
- Hazards: combinational compare of rs_chk/rt_chk against every valid entry.
  - Index 0 never raises a hazard.
  - Same-cycle pushes are not visible until the next cycle.
  - A head entry being popped still hazards in that cycle.
- full and empty are derived from the registered count; no combinational path from push/pop.

Optional Feature:
Macro REG_DST_ZERO_DROP_EN.
- Defined: a push whose selected destination is 0 is accepted as a handshake but not stored. count and wr_ptr are unchanged; if the queue is full, the push still succeeds with no effect.
- Undefined: index 0 is enqueued like any other index. It occupies an entry but still never raises a hazard.

Test Plan:
1. Reset, then Reg_Dst=00/01/10/11 with rt=5, rd=9 -> dst_out = 5, 9, 31, 29; empty=1, count=0.
2. Reg_Dst=01, rd=7, push 1 cycle -> next cycle count=1, head_dst=7, hazard_rs=1 for rs_chk=7, 0 for rs_chk=8.
3. Push rd=1,2,3,4 (DEPTH=4), then push rd=6 -> full=1, 6 dropped. Pop four times -> head_dst sequence 1,2,3,4, then empty=1 and head_dst=0.
4. Full queue, push rd=10 with pop in the same cycle -> count stays 4; after three pops head_dst=10. Confirms wrap-around.
5. Three entries pending, assert flush together with push -> next cycle count=0, empty=1, no hazards; the pushed value is lost.
6. Push Reg_Dst=00 with rt=0 -> without the macro count=1 and hazard_rs=0 for rs_chk=0; with REG_DST_ZERO_DROP_EN count=0.
